// File: rtl/unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : unit_pkg                                                      |
// | Brief    : Shared types, constants and width helpers for unit_mton.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package unit_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FWD  = 3'd1,
        BWD  = 3'd2,
        UPD  = 3'd3,
        READ = 3'd4
    } state_t;

    localparam logic c_W_RST = 1'b1;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to index n items, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Bits needed to hold a population count in 0..n.
    function automatic int pop_width(input int n);
        return (n <= 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/unit_xnor_majority.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : unit_xnor_majority                                            |
// | Brief    : maj = (2 * popcount(~(a ^ b)) >= N); ties resolve to 1.       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module unit_xnor_majority
    import unit_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = pop_width(N)
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         maj
);

    logic [N-1:0]  w_eq;
    logic [PW-1:0] w_pop;

    assign w_eq = ~(a ^ b);

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < N; k++) begin
            w_pop = w_pop + PW'(w_eq[k]);
        end
    end

    assign maj = ({w_pop, 1'b0} >= (PW + 1)'(N));

endmodule
`default_nettype wire

// File: rtl/unit_mton.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : unit_mton                                                     |
// | Brief    : Binary-neuron layer: XNOR-majority forward/backward passes,   |
// |            error-driven weight update and serial weight readback.        |
// |            Define UNIT_STOCHASTIC_EN to gate updates with `oscillator`.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module unit_mton
    import unit_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int N_OUT = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             oscillator,
    input  logic             fd_prop,
    input  logic             bk_prop,
    input  logic             rd_weights,
    input  logic [N_IN-1:0]  fin,
    input  logic [N_OUT-1:0] bin,
    output logic [N_OUT-1:0] fout,
    output logic [N_IN-1:0]  bout,
    output logic             control_out,
    output logic             control_valid,
    output logic             busy,
    output logic             done
);

    localparam int PW = pop_width(imax(N_IN, N_OUT));
    localparam int IW = cnt_width(imax(imax(N_IN, N_OUT), N_IN * N_OUT));
    localparam logic [IW-1:0] c_LAST_COL = IW'(N_OUT - 1);
    localparam logic [IW-1:0] c_LAST_ROW = IW'(N_IN - 1);
    localparam logic [IW-1:0] c_LAST_BIT = IW'(N_IN * N_OUT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    w_idx_nxt;
    logic             w_last;

    logic [N_OUT-1:0] r_w [N_IN];
    logic [N_IN-1:0]  r_fin_q;
    logic [N_OUT-1:0] r_bin_q;
    logic [N_OUT-1:0] r_shadow;
    logic [N_IN-1:0]  r_bshadow;
    logic [N_OUT-1:0] r_fout;
    logic [N_IN-1:0]  r_bout;
    logic             r_ctl_out;
    logic             r_ctl_vld;
    logic             r_fin_pend;
    logic             r_fout_pend;
    logic             r_done;

    logic [N_IN-1:0]  w_col;
    logic [N_OUT-1:0] w_row;
    logic             w_rd_bit;
    logic             w_fmaj;
    logic             w_bmaj;
    logic [N_OUT-1:0] w_shadow_nxt;
    logic [N_IN-1:0]  w_bshadow_nxt;
    logic             w_gate;

`ifdef UNIT_STOCHASTIC_EN
    assign w_gate = oscillator;
`else
    logic w_unused_osc;
    assign w_unused_osc = oscillator;
    assign w_gate       = 1'b1;
`endif

    // Column, row and readback bit selected by the shared index counter.
    always_comb begin
        w_col    = '0;
        w_row    = '0;
        w_rd_bit = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            for (int j = 0; j < N_OUT; j++) begin
                if (r_idx == IW'(j))              w_col[i] = r_w[i][j];
                if (r_idx == IW'(i))              w_row[j] = r_w[i][j];
                if (r_idx == IW'(i * N_OUT + j))  w_rd_bit = r_w[i][j];
            end
        end
    end

    unit_xnor_majority #(.N(N_IN), .PW(PW)) u_fwd_maj (
        .a   (r_fin_q),
        .b   (w_col),
        .maj (w_fmaj)
    );

    unit_xnor_majority #(.N(N_OUT), .PW(PW)) u_bwd_maj (
        .a   (r_bin_q),
        .b   (w_row),
        .maj (w_bmaj)
    );

    always_comb begin
        w_shadow_nxt  = r_shadow;
        w_bshadow_nxt = r_bshadow;
        for (int j = 0; j < N_OUT; j++) begin
            if (r_idx == IW'(j)) w_shadow_nxt[j] = w_fmaj;
        end
        for (int i = 0; i < N_IN; i++) begin
            if (r_idx == IW'(i)) w_bshadow_nxt[i] = w_bmaj;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last      = 1'b0;
        w_idx_nxt   = r_idx + 1'b1;
        case (r_state)
            IDLE: begin
                w_idx_nxt = '0;
                if (fd_prop)         w_state_nxt = FWD;
                else if (bk_prop)    w_state_nxt = BWD;
                else if (rd_weights) w_state_nxt = READ;
            end
            FWD: if (r_idx == c_LAST_COL) begin
                w_last      = 1'b1;
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
            BWD: if (r_idx == c_LAST_ROW) begin
                w_state_nxt = UPD;
                w_idx_nxt   = '0;
            end
            UPD: if (r_idx == c_LAST_COL) begin
                w_last      = 1'b1;
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
            READ: if (r_idx == c_LAST_BIT) begin
                w_last      = 1'b1;
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // done (and the forward result) land one edge after the final step.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_idx       <= '0;
            r_fin_q     <= '0;
            r_bin_q     <= '0;
            r_shadow    <= '0;
            r_bshadow   <= '0;
            r_fout      <= '0;
            r_bout      <= '0;
            r_ctl_out   <= 1'b0;
            r_ctl_vld   <= 1'b0;
            r_fin_pend  <= 1'b0;
            r_fout_pend <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_idx       <= w_idx_nxt;
            r_fin_pend  <= w_last;
            r_done      <= r_fin_pend;
            r_fout_pend <= w_last && (r_state == FWD);
            r_ctl_vld   <= 1'b0;
            if (r_fout_pend) r_fout <= r_shadow;
            case (r_state)
                IDLE: begin
                    if (fd_prop)      r_fin_q <= fin;
                    else if (bk_prop) r_bin_q <= bin;
                end
                FWD:  r_shadow <= w_shadow_nxt;
                BWD: begin
                    r_bshadow <= w_bshadow_nxt;
                    if (r_idx == c_LAST_ROW) r_bout <= w_bshadow_nxt;
                end
                READ: begin
                    r_ctl_out <= w_rd_bit;
                    r_ctl_vld <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < N_IN; i++) r_w[i] <= {N_OUT{c_W_RST}};
        end else if (r_state == UPD) begin
            for (int j = 0; j < N_OUT; j++) begin
                if ((r_idx == IW'(j)) && (r_fout[j] != r_bin_q[j]) && w_gate) begin
                    for (int i = 0; i < N_IN; i++) r_w[i][j] <= ~(r_fin_q[i] ^ r_bin_q[j]);
                end
            end
        end
    end

    assign fout          = r_fout;
    assign bout          = r_bout;
    assign control_out   = r_ctl_out;
    assign control_valid = r_ctl_vld;
    assign busy          = (r_state != IDLE);
    assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_unit_mton.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_unit_mton                                                  |
// | Brief    : Directed scoreboard bench for unit_mton (3x3).                |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_unit_mton;

    localparam int N_IN  = 3;
    localparam int N_OUT = 3;
    localparam int K_FWD  = 0;
    localparam int K_BWD  = 1;
    localparam int K_READ = 2;
    localparam int K_BOTH = 3;
    localparam logic [8:0] c_PAT_UPD  = 9'b111010010;
    localparam logic [8:0] c_PAT_ONES = 9'b111111111;
`ifdef UNIT_STOCHASTIC_EN
    localparam logic [8:0] c_PAT_OSC0 = c_PAT_ONES;
`else
    localparam logic [8:0] c_PAT_OSC0 = c_PAT_UPD;
`endif

    logic             clk_in     = 1'b0;
    logic             rst_in     = 1'b0;
    logic             oscillator = 1'b0;
    logic             fd_prop    = 1'b0;
    logic             bk_prop    = 1'b0;
    logic             rd_weights = 1'b0;
    logic [N_IN-1:0]  fin        = '0;
    logic [N_OUT-1:0] bin        = '0;
    logic [N_OUT-1:0] fout;
    logic [N_IN-1:0]  bout;
    logic             control_out;
    logic             control_valid;
    logic             busy;
    logic             done;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];

    unit_mton #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .oscillator    (oscillator),
        .fd_prop       (fd_prop),
        .bk_prop       (bk_prop),
        .rd_weights    (rd_weights),
        .fin           (fin),
        .bin           (bin),
        .fout          (fout),
        .bout          (bout),
        .control_out   (control_out),
        .control_valid (control_valid),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [31:0] sb_pop();
        if (sb_q.size() == 0) return 32'hDEAD_BEEF;
        return sb_q.pop_front();
    endfunction

    task automatic push_bits(input logic [8:0] pat);
        for (int k = 8; k >= 0; k--) sb_q.push_back({31'b0, pat[k]});
    endtask

    task automatic apply_reset();
        rst_in = 1'b0;
        #1;
        check("rst fout", {29'b0, fout}, 0);
        check("rst bout", {29'b0, bout}, 0);
        check("rst busy", {31'b0, busy}, 0);
        check("rst done", {31'b0, done}, 0);
        check("rst control_valid", {31'b0, control_valid}, 0);
        check("rst control_out", {31'b0, control_out}, 0);
        tick();
        tick();
        rst_in = 1'b1;
        tick();
    endtask

    // Issue one request and follow it to its done pulse.
    task automatic run_op(input string tag, input int kind, input int exp_lat,
                          input int exp_busy, input int exp_vld);
        int n        = 0;
        int busy_cnt = 0;
        int vld_cnt  = 0;
        fd_prop    = (kind == K_FWD) || (kind == K_BOTH);
        bk_prop    = (kind == K_BWD) || (kind == K_BOTH);
        rd_weights = (kind == K_READ);
        tick();
        fd_prop    = 1'b0;
        bk_prop    = 1'b0;
        rd_weights = 1'b0;
        while (!done && n < 60) begin
            if (busy) busy_cnt++;
            if (control_valid) begin
                vld_cnt++;
                check({tag, " bit"}, {31'b0, control_out}, sb_pop());
            end
            tick();
            n++;
        end
        check({tag, " latency"}, n, exp_lat);
        check({tag, " busy cycles"}, busy_cnt, exp_busy);
        check({tag, " valid cycles"}, vld_cnt, exp_vld);
        check({tag, " valid at done"}, {31'b0, control_valid}, 0);
        if (kind == K_FWD || kind == K_BOTH) check({tag, " fout"}, {29'b0, fout}, sb_pop());
        if (kind == K_BWD)                   check({tag, " bout"}, {29'b0, bout}, sb_pop());
        tick();
        check({tag, " done single"}, {31'b0, done}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;

        // Forward passes on reset weights, then an update with oscillator=0.
        @(posedge clk_in);
        apply_reset();
        fin = 3'b011;
        sb_q.push_back(32'b111);
        run_op("fwd011", K_FWD, 4, 3, 0);
        fin = 3'b001;
        sb_q.push_back(32'b000);
        run_op("fwd001", K_FWD, 4, 3, 0);
        bin = 3'b101;
        oscillator = 1'b0;
        sb_q.push_back(32'b111);
        run_op("bwd osc0", K_BWD, 7, 6, 0);
        push_bits(c_PAT_OSC0);
        run_op("read osc0", K_READ, 10, 9, 9);

        // Same sequence from reset with oscillator=1.
        apply_reset();
        oscillator = 1'b1;
        fin = 3'b001;
        sb_q.push_back(32'b000);
        run_op("fwd001 b", K_FWD, 4, 3, 0);
        bin = 3'b101;
        sb_q.push_back(32'b111);
        run_op("bwd osc1", K_BWD, 7, 6, 0);
        push_bits(c_PAT_UPD);
        run_op("read osc1", K_READ, 10, 9, 9);

        // fd_prop and bk_prop together: forward wins, weights stay put.
        fin = 3'b011;
        bin = 3'b000;
        sb_q.push_back(32'b111);
        run_op("collide", K_BOTH, 4, 3, 0);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (done || busy) cnt++;
            tick();
        end
        check("collide no upd", cnt, 0);
        push_bits(c_PAT_UPD);
        run_op("read collide", K_READ, 10, 9, 9);

        // fd_prop re-pulsed mid-FWD must be ignored.
        fin = 3'b000;
        fd_prop = 1'b1;
        sb_q.push_back(32'b101);
        tick();
        fd_prop = 1'b0;
        tick();
        fin = 3'b011;
        fd_prop = 1'b1;
        tick();
        fd_prop = 1'b0;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) begin
                cnt++;
                check("refire fout", {29'b0, fout}, sb_pop());
            end
            tick();
        end
        check("refire done count", cnt, 1);

        // Reset asserted in the middle of a readback.
        rd_weights = 1'b1;
        tick();
        rd_weights = 1'b0;
        n = 0;
        cnt = 0;
        while (cnt < 4 && n < 30) begin
            tick();
            n++;
            if (control_valid) cnt++;
        end
        check("midread bits seen", cnt, 4);
        rst_in = 1'b0;
        #1;
        check("midread control_valid", {31'b0, control_valid}, 0);
        check("midread busy", {31'b0, busy}, 0);
        check("midread done", {31'b0, done}, 0);
        tick();
        rst_in = 1'b1;
        tick();
        push_bits(c_PAT_ONES);
        run_op("read after rst", K_READ, 10, 9, 9);

        check("scoreboard empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
